// File: rtl/dmac_bus_pkg.sv
// Shared types and helpers for the DMAC two-master bus arbiter.
//   htrans_e     : AHB-lite HTRANS encoding
//   arb_state_e  : arbiter ownership states
//   MST_CPU/DMA  : master IDs as driven on HMaster / HMaster_D
//   is_boundary  : transfer boundary (a point where the grant may move)
//   is_xfer      : HTRANS value that carries a real transfer (NONSEQ/SEQ)
package dmac_bus_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [0:0] {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } arb_state_e;

   localparam logic MST_CPU = 1'b0;
   localparam logic MST_DMA = 1'b1;

   // A burst may only be interrupted before its first beat or after its
   // last one: SEQ/BUSY mean mid-burst, HReady low means the bus is stalled.
   function automatic logic is_boundary(input logic hready, input logic [1:0] htrans);
      return hready && ((htrans == HT_IDLE) || (htrans == HT_NONSEQ));
   endfunction

   function automatic logic is_xfer(input logic [1:0] htrans);
      return (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
   endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating hold counter used to bound how long one master may keep the
// bus while the other one is waiting.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   inc_i  : count one accepted transfer (ignored once saturated)
//   clr_i  : clear to 0; takes priority over inc_i
//   sat_o  : count has reached MAX
module arb_hold_counter #(
   parameter int CNT_W = 5,
   parameter int MAX   = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign sat_o = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmac_bus_arbiter.sv
// Two-master AHB-lite arbiter between the CPU (master 0) and the DMAC
// (master 1). The CPU is the parked default owner. Ownership moves only on
// transfer boundaries so bursts are never split, and two hold counters stop
// either master from starving the other.
//   clk, rst              : clock, synchronous active-high reset
//   Cpu_Req, Cpu_HTrans   : CPU request and HTRANS
//   Dma_Req, Dma_HTrans   : DMAC Bus_Req and MTrans
//   HReady                : bus HREADY
//   Cpu_Grant, Dma_Grant  : one-hot address-phase grants
//   HMaster               : address-phase owner (address/control mux select)
//   HMaster_D             : data-phase owner (HWDATA mux, HRDATA/HRESP routing)
module dmac_bus_arbiter
   import dmac_bus_pkg::*;
#(
   parameter int MAX_DMA_HOLD = 16,
   parameter int CPU_QUANTUM  = 4,
   parameter int CNT_W        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Cpu_Req,
   input  logic [1:0] Cpu_HTrans,
   input  logic       Dma_Req,
   input  logic [1:0] Dma_HTrans,
   input  logic       HReady,
   output logic       Cpu_Grant,
   output logic       Dma_Grant,
   output logic       HMaster,
   output logic       HMaster_D
);

   localparam logic [0:0] S_CPU_OWN = CPU_OWN;
   localparam logic [0:0] S_DMA_OWN = DMA_OWN;

   logic [0:0] state_q;
   logic [0:0] state_d;
   logic       hmaster_d_q;
   logic       owner_is_dma;
   logic [1:0] owner_htrans;
   logic       bnd;
   logic       state_chg;
   logic       cpu_inc;
   logic       cpu_clr;
   logic       cpu_sat;
   logic       dma_inc;
   logic       dma_clr;
   logic       dma_sat;

   assign owner_is_dma = (state_q == S_DMA_OWN);
   assign owner_htrans = owner_is_dma ? Dma_HTrans : Cpu_HTrans;
   assign bnd          = is_boundary(HReady, owner_htrans);

   always_comb begin
      state_d = state_q;
      if (bnd) begin
         case (state_q)
            S_CPU_OWN: begin
               if (Dma_Req && (!Cpu_Req || cpu_sat)) begin
                  state_d = S_DMA_OWN;
               end
            end
            default: begin
               if (!Dma_Req || (Cpu_Req && dma_sat)) begin
                  state_d = S_CPU_OWN;
               end
            end
         endcase
      end
   end

   assign state_chg = (state_d != state_q);

   // Counters only accumulate while the other master is actually waiting;
   // a change of owner or the waiter dropping its request restarts them.
   assign cpu_inc = !owner_is_dma && HReady && is_xfer(Cpu_HTrans) && Dma_Req;
   assign cpu_clr = state_chg || !Dma_Req;
   assign dma_inc = owner_is_dma && HReady && is_xfer(Dma_HTrans) && Cpu_Req;
   assign dma_clr = state_chg || !Cpu_Req;

   arb_hold_counter #(
      .CNT_W (CNT_W),
      .MAX   (CPU_QUANTUM)
   ) u_cpu_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (cpu_inc),
      .clr_i (cpu_clr),
      .sat_o (cpu_sat)
   );

   arb_hold_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_DMA_HOLD)
   ) u_dma_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (dma_inc),
      .clr_i (dma_clr),
      .sat_o (dma_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CPU_OWN;
         hmaster_d_q <= MST_CPU;
      end else begin
         state_q <= state_d;
         // The data phase follows the address phase by one accepted cycle,
         // so the beat issued in a switching cycle still routes to the old owner.
         if (HReady) begin
            hmaster_d_q <= owner_is_dma ? MST_DMA : MST_CPU;
         end
      end
   end

   assign Cpu_Grant = (state_q == S_CPU_OWN);
   assign Dma_Grant = (state_q == S_DMA_OWN);
   assign HMaster   = owner_is_dma ? MST_DMA : MST_CPU;
   assign HMaster_D = hmaster_d_q;

endmodule
